// File: rtl/factory_slot_arbiter.sv
// Slot allocator: round-robin arbitration between requesters, lowest-free-slot
// handle assignment, per-slot family tags, and a release port with double-free detection.
module factory_slot_arbiter #(
    parameter int  NUM_REQ   = 4,
    parameter int  NUM_SLOTS = 8,
    parameter int  FAMILY_W  = 2,
    localparam int HANDLE_W  = $clog2(NUM_SLOTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FAMILY_W-1:0]   req_family,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [HANDLE_W-1:0]           gnt_handle,
    output logic [FAMILY_W-1:0]           gnt_family,
    input  logic                          rel_valid,
    input  logic [HANDLE_W-1:0]           rel_handle,
    output logic [NUM_SLOTS*FAMILY_W-1:0] slot_family,
    output logic [HANDLE_W:0]             free_count,
    output logic                          full,
    output logic                          err_double_free
);
    localparam int SPAN = 1 << HANDLE_W;
    localparam int RR_W = $clog2(NUM_REQ);

    logic [NUM_SLOTS-1:0] used;
    logic [SPAN-1:0]      used_ext;
    logic [RR_W-1:0]      rr_ptr;
    logic [RR_W-1:0]      rr_next;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [FAMILY_W-1:0]  win_family;
    logic                 any_win;
    logic [HANDLE_W-1:0]  free_idx;
    logic [HANDLE_W:0]    free_cnt;
    logic                 grant_ok;
    logic                 rel_ok;
    logic                 rel_bad;

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin
        win_onehot = '0;
        win_family = '0;
        any_win    = 1'b0;
        rr_next    = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any_win && req[idx]) begin
                any_win         = 1'b1;
                win_onehot[idx] = 1'b1;
                win_family      = req_family[idx*FAMILY_W +: FAMILY_W];
                rr_next         = RR_W'((idx + 1) % NUM_REQ);
            end
        end
    end

    // Lowest free slot and free population, both from the registered map so
    // a same-cycle release is never visible to this cycle's grant.
    always_comb begin
        free_idx = '0;
        free_cnt = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!used[i]) begin
                free_idx = HANDLE_W'(i);
                free_cnt = free_cnt + 1'b1;
            end
        end
    end

    // Handles beyond NUM_SLOTS read as free so they flag as a bad release.
    always_comb begin
        used_ext                = '0;
        used_ext[NUM_SLOTS-1:0] = used;
    end

    assign free_count = free_cnt;
    assign full       = (free_cnt == '0);
    assign grant_ok   = any_win && !full;
    assign rel_ok     = rel_valid && used_ext[rel_handle];
    assign rel_bad    = rel_valid && !used_ext[rel_handle];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            used            <= '0;
            slot_family     <= '0;
            gnt             <= '0;
            gnt_handle      <= '0;
            gnt_family      <= '0;
            err_double_free <= 1'b0;
            rr_ptr          <= '0;
        end else begin
            err_double_free <= rel_bad;
            gnt             <= grant_ok ? win_onehot : '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (grant_ok && free_idx == HANDLE_W'(i)) begin
                    used[i]                            <= 1'b1;
                    slot_family[i*FAMILY_W +: FAMILY_W] <= win_family;
                end else if (rel_ok && rel_handle == HANDLE_W'(i)) begin
                    used[i]                            <= 1'b0;
                    slot_family[i*FAMILY_W +: FAMILY_W] <= '0;
                end
            end
            if (grant_ok) begin
                gnt_handle <= free_idx;
                gnt_family <= win_family;
                rr_ptr     <= rr_next;
            end
        end
    end
endmodule

// File: tb/tb_factory_slot_arbiter.sv
// Directed bench for factory_slot_arbiter: main 4x8 instance plus a 9-slot
// instance whose 4-bit handle can address beyond the pool.
module tb_factory_slot_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  req_family;
    logic [3:0]  gnt;
    logic [2:0]  gnt_handle;
    logic [1:0]  gnt_family;
    logic        rel_valid;
    logic [2:0]  rel_handle;
    logic [15:0] slot_family;
    logic [3:0]  free_count;
    logic        full;
    logic        err_double_free;

    logic [3:0]  b_req;
    logic [7:0]  b_req_family;
    logic [3:0]  b_gnt;
    logic [3:0]  b_gnt_handle;
    logic [1:0]  b_gnt_family;
    logic        b_rel_valid;
    logic [3:0]  b_rel_handle;
    logic [17:0] b_slot_family;
    logic [4:0]  b_free_count;
    logic        b_full;
    logic        b_err;

    int tests_run = 0;
    int tests_failed = 0;

    factory_slot_arbiter #(.NUM_REQ(4), .NUM_SLOTS(8), .FAMILY_W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_family(req_family),
        .gnt(gnt), .gnt_handle(gnt_handle), .gnt_family(gnt_family),
        .rel_valid(rel_valid), .rel_handle(rel_handle),
        .slot_family(slot_family), .free_count(free_count), .full(full),
        .err_double_free(err_double_free)
    );

    factory_slot_arbiter #(.NUM_REQ(4), .NUM_SLOTS(9), .FAMILY_W(2)) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .req_family(b_req_family),
        .gnt(b_gnt), .gnt_handle(b_gnt_handle), .gnt_family(b_gnt_family),
        .rel_valid(b_rel_valid), .rel_handle(b_rel_handle),
        .slot_family(b_slot_family), .free_count(b_free_count), .full(b_full),
        .err_double_free(b_err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        req = '0; req_family = '0; rel_valid = 1'b0; rel_handle = '0;
        b_req = '0; b_req_family = '0; b_rel_valid = 1'b0; b_rel_handle = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (gnt !== 4'b0000 || gnt_handle !== 3'd0 || gnt_family !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_gnt: got gnt=%b h=%0d f=%0d want 0000/0/0", gnt, gnt_handle, gnt_family);
        end
        tests_run++;
        if (free_count !== 4'd8 || full !== 1'b0 || err_double_free !== 1'b0 || slot_family !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_pool: got fc=%0d full=%b err=%b sf=%h want 8/0/0/0000",
                     free_count, full, err_double_free, slot_family);
        end
    endtask

    task automatic test_single();
        req = 4'b0001; req_family = 8'b00_00_00_10;
        @(negedge clk);
        req = 4'b0000;
        tests_run++;
        if (gnt !== 4'b0001 || gnt_handle !== 3'd0 || gnt_family !== 2'd2) begin
            tests_failed++;
            $display("FAIL single_grant: got gnt=%b h=%0d f=%0d want 0001/0/2", gnt, gnt_handle, gnt_family);
        end
        tests_run++;
        if (free_count !== 4'd7 || slot_family[1:0] !== 2'd2) begin
            tests_failed++;
            $display("FAIL single_pool: got fc=%0d sf0=%0d want 7/2", free_count, slot_family[1:0]);
        end
        @(negedge clk);
        tests_run++;
        if (gnt !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_pulse: got gnt=%b want 0000", gnt);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 4'b1111; req_family = {2'd3, 2'd2, 2'd1, 2'd0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (gnt !== 4'(1 << i) || gnt_handle !== 3'(i) || gnt_family !== 2'(i)) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: got gnt=%b h=%0d f=%0d want %b/%0d/%0d",
                         i, gnt, gnt_handle, gnt_family, 4'(1 << i), i, i);
            end
        end
        req = 4'b0000;
        tests_run++;
        if (free_count !== 4'd4 || slot_family !== 16'h00E4) begin
            tests_failed++;
            $display("FAIL rr_pool: got fc=%0d sf=%h want 4/00e4", free_count, slot_family);
        end
    endtask

    task automatic test_full_release();
        do_reset();
        req = 4'b1111; req_family = 8'h55;
        repeat (8) @(negedge clk);
        req = 4'b0100; req_family = 8'h30;
        tests_run++;
        if (full !== 1'b1 || free_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL full_flag: got full=%b fc=%0d want 1/0", full, free_count);
        end
        @(negedge clk);
        tests_run++;
        if (gnt !== 4'b0000) begin
            tests_failed++;
            $display("FAIL full_no_grant: got gnt=%b want 0000", gnt);
        end
        rel_valid = 1'b1; rel_handle = 3'd5;
        @(negedge clk);
        rel_valid = 1'b0;
        tests_run++;
        if (gnt !== 4'b0000 || free_count !== 4'd1 || full !== 1'b0 || slot_family[11:10] !== 2'd0) begin
            tests_failed++;
            $display("FAIL full_release: got gnt=%b fc=%0d full=%b sf5=%0d want 0000/1/0/0",
                     gnt, free_count, full, slot_family[11:10]);
        end
        @(negedge clk);
        req = 4'b0000;
        tests_run++;
        if (gnt !== 4'b0100 || gnt_handle !== 3'd5 || gnt_family !== 2'd3 || full !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_regrant: got gnt=%b h=%0d f=%0d full=%b want 0100/5/3/1",
                     gnt, gnt_handle, gnt_family, full);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        req = 4'b1111; req_family = 8'h55;
        repeat (4) @(negedge clk);
        req = 4'b0001; req_family = 8'h02;
        rel_valid = 1'b1; rel_handle = 3'd0;
        @(negedge clk);
        req = 4'b0000; rel_valid = 1'b0;
        tests_run++;
        if (gnt !== 4'b0001 || gnt_handle !== 3'd4 || gnt_family !== 2'd2) begin
            tests_failed++;
            $display("FAIL same_cycle_grant: got gnt=%b h=%0d f=%0d want 0001/4/2", gnt, gnt_handle, gnt_family);
        end
        tests_run++;
        if (free_count !== 4'd4 || slot_family[1:0] !== 2'd0 || slot_family[9:8] !== 2'd2 || err_double_free !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_cycle_pool: got fc=%0d sf0=%0d sf4=%0d err=%b want 4/0/2/0",
                     free_count, slot_family[1:0], slot_family[9:8], err_double_free);
        end
    endtask

    task automatic test_double_free();
        rel_valid = 1'b1; rel_handle = 3'd6;
        b_rel_valid = 1'b1; b_rel_handle = 4'd9;
        @(negedge clk);
        rel_valid = 1'b0; b_rel_valid = 1'b0;
        tests_run++;
        if (err_double_free !== 1'b1 || free_count !== 4'd4) begin
            tests_failed++;
            $display("FAIL double_free: got err=%b fc=%0d want 1/4", err_double_free, free_count);
        end
        tests_run++;
        if (b_err !== 1'b1 || b_free_count !== 5'd9) begin
            tests_failed++;
            $display("FAIL out_of_range: got err=%b fc=%0d want 1/9", b_err, b_free_count);
        end
        @(negedge clk);
        tests_run++;
        if (err_double_free !== 1'b0 || b_err !== 1'b0 || free_count !== 4'd4) begin
            tests_failed++;
            $display("FAIL err_pulse: got err=%b b_err=%b fc=%0d want 0/0/4", err_double_free, b_err, free_count);
        end
        rel_valid = 1'b1; rel_handle = 3'd1;
        @(negedge clk);
        rel_valid = 1'b0;
        tests_run++;
        if (err_double_free !== 1'b0 || free_count !== 4'd5) begin
            tests_failed++;
            $display("FAIL good_release: got err=%b fc=%0d want 0/5", err_double_free, free_count);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        req = 4'b0111; req_family = 8'h00;
        repeat (3) @(negedge clk);
        req = 4'b0110;
        @(negedge clk);
        tests_run++;
        if (gnt !== 4'b0010 || gnt_handle !== 3'd3) begin
            tests_failed++;
            $display("FAIL midop_pre: got gnt=%b h=%0d want 0010/3", gnt, gnt_handle);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (gnt !== 4'b0000 || free_count !== 4'd8 || full !== 1'b0 || slot_family !== 16'h0) begin
            tests_failed++;
            $display("FAIL midop_async: got gnt=%b fc=%0d full=%b sf=%h want 0000/8/0/0000",
                     gnt, free_count, full, slot_family);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req = 4'b0000;
        tests_run++;
        if (gnt !== 4'b0010 || gnt_handle !== 3'd0 || free_count !== 4'd7) begin
            tests_failed++;
            $display("FAIL midop_regrant: got gnt=%b h=%0d fc=%0d want 0010/0/7", gnt, gnt_handle, free_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0; req_family = '0; rel_valid = 1'b0; rel_handle = '0;
        b_req = '0; b_req_family = '0; b_rel_valid = 1'b0; b_rel_handle = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_release();
        test_same_cycle();
        test_double_free();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
